// File: rtl/counter_pkg.sv
// Shared constants and terminal-value helper for the bn_counter family.
// Optional saturating mode is selected by BN_COUNTER_SAT_EN.
package counter_pkg;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   function automatic logic term(
      input logic [31:0] q,
      input logic        up,
      input logic [31:0] m
   );
      return (up == DIR_UP) ? (q == m - 32'd1) : (q == 32'd0);
   endfunction

endpackage

// File: rtl/bn_counter_next.sv
// Next-count and terminal detect for one counter digit.
// BN_COUNTER_SAT_EN selects hold-at-terminal instead of wrap.
module bn_counter_next
   import counter_pkg::*;
#(
   parameter int N   = 4,
   parameter int MOD = 2 ** N
) (
   input  logic [N-1:0] q,
   input  logic         up,
   output logic [N-1:0] nxt,
   output logic         at_term
);

   localparam logic [N-1:0] MAXV = N'(MOD - 1);

`ifdef BN_COUNTER_SAT_EN
   localparam logic [N-1:0] UP_END = MAXV;
   localparam logic [N-1:0] DN_END = '0;
`else
   localparam logic [N-1:0] UP_END = '0;
   localparam logic [N-1:0] DN_END = MAXV;
`endif

   assign at_term = term(32'(q), up, 32'(MOD));

   always_comb begin
      nxt = q;
      if (up == DIR_UP)
         nxt = at_term ? UP_END : q + N'(1);
      else
         nxt = at_term ? DN_END : q - N'(1);
   end

endmodule

// File: rtl/bn_counter.sv
// Cascadable N-bit modulo counter with load, direction and sticky overflow.
// Define BN_COUNTER_SAT_EN for saturating instead of wrapping behaviour.
module bn_counter
   import counter_pkg::*;
#(
   parameter int N   = 4,
   parameter int MOD = 2 ** N
) (
   input  logic         clock,
   input  logic         reset_,
   input  logic         ei,
   input  logic         up,
   input  logic         ld,
   input  logic [N-1:0] din,
   input  logic         clr_ov,
   output logic [N-1:0] q,
   output logic         eu,
   output logic         ov
);

   localparam logic [N-1:0] MAXV = N'(MOD - 1);

   logic [N-1:0] nxt;
   logic         at_term;

   bn_counter_next #(
      .N   (N),
      .MOD (MOD)
   ) u_next (
      .q       (q),
      .up      (up),
      .nxt     (nxt),
      .at_term (at_term)
   );

   // eu doubles as the overflow event: a step taken from the terminal value
   assign eu = ei & ~ld & at_term;

   always_ff @(posedge clock) begin
      if (!reset_) begin
         q  <= '0;
         ov <= 1'b0;
      end else begin
         if (ld)
            q <= (din > MAXV) ? MAXV : din;
         else if (ei)
            q <= nxt;
         if (eu)
            ov <= 1'b1;
         else if (clr_ov)
            ov <= 1'b0;
      end
   end

endmodule

// File: tb/tb_bn_counter.sv
// Randomised and directed checks of bn_counter against an arithmetic model.
// Honours BN_COUNTER_SAT_EN to select the saturating reference behaviour.
module tb_bn_counter;

   localparam int N   = 4;
   localparam int MOD = 10;

   logic         clock;
   logic         reset_;
   logic         ei;
   logic         up;
   logic         ld;
   logic [N-1:0] din;
   logic         clr_ov;
   logic [N-1:0] q;
   logic         eu;
   logic         ov;

   logic         c_rst;
   logic         c_ei;
   logic [N-1:0] lo_q;
   logic [N-1:0] hi_q;
   logic         lo_eu;
   logic         hi_eu;
   logic         lo_ov;
   logic         hi_ov;

   int checks = 0;
   int errors = 0;
   int mq     = 0;
   bit mov    = 0;

   bn_counter #(.N(N), .MOD(MOD)) dut (
      .clock  (clock),
      .reset_ (reset_),
      .ei     (ei),
      .up     (up),
      .ld     (ld),
      .din    (din),
      .clr_ov (clr_ov),
      .q      (q),
      .eu     (eu),
      .ov     (ov)
   );

   bn_counter #(.N(N), .MOD(MOD)) lo (
      .clock  (clock),
      .reset_ (c_rst),
      .ei     (c_ei),
      .up     (1'b1),
      .ld     (1'b0),
      .din    (4'd0),
      .clr_ov (1'b0),
      .q      (lo_q),
      .eu     (lo_eu),
      .ov     (lo_ov)
   );

   bn_counter #(.N(N), .MOD(MOD)) hi (
      .clock  (clock),
      .reset_ (c_rst),
      .ei     (lo_eu),
      .up     (1'b1),
      .ld     (1'b0),
      .din    (4'd0),
      .clr_ov (1'b0),
      .q      (hi_q),
      .eu     (hi_eu),
      .ov     (hi_ov)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, check eu before the edge, q/ov after it.
   task automatic cyc(input bit r, input bit e, input bit u,
                      input bit l, input int d, input bit c);
      bit meu;
      reset_ = r;
      ei     = e;
      up     = u;
      ld     = l;
      din    = N'(d);
      clr_ov = c;
      #1;
      meu = e && !l && (u ? (mq == MOD - 1) : (mq == 0));
      chk("eu", 32'(eu), 32'(meu));
      @(posedge clock);
      #1;
      if (!r) begin
         mq  = 0;
         mov = 0;
      end else begin
         if (l)
            mq = (d >= MOD) ? MOD - 1 : d;
         else if (e) begin
`ifdef BN_COUNTER_SAT_EN
            if (u)
               mq = (mq + 1 > MOD - 1) ? MOD - 1 : mq + 1;
            else
               mq = (mq == 0) ? 0 : mq - 1;
`else
            mq = u ? (mq + 1) % MOD : (mq + MOD - 1) % MOD;
`endif
         end
         mov = meu || (mov && !c);
      end
      chk("q", 32'(q), 32'(mq));
      chk("ov", 32'(ov), 32'(mov));
   endtask

   initial begin
      int pulses;
      reset_ = 1'b0;
      ei     = 1'b0;
      up     = 1'b1;
      ld     = 1'b0;
      din    = '0;
      clr_ov = 1'b0;
      c_rst  = 1'b0;
      c_ei   = 1'b0;

      // reset, then build q=7 with ov=1, then reset over it
      cyc(0, 0, 1, 0, 0, 0);
      cyc(1, 0, 1, 1, 9, 0);
      cyc(1, 1, 1, 0, 0, 0);
      cyc(1, 0, 1, 1, 7, 0);
      cyc(0, 1, 1, 0, 0, 0);
      cyc(0, 1, 1, 1, 5, 0);

      // up count through the wrap
      cyc(1, 0, 1, 1, 0, 1);
      for (int i = 0; i < 12; i++)
         cyc(1, 1, 1, 0, 0, 0);

      // down through zero, then clamped load
      cyc(1, 0, 0, 1, 1, 1);
      cyc(1, 1, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0);
      cyc(1, 1, 0, 1, 13, 0);
      cyc(1, 1, 1, 1, 15, 0);

      // wrap coinciding with clear, then clear alone
      cyc(1, 0, 1, 1, 9, 1);
      cyc(1, 1, 1, 0, 0, 1);
      cyc(1, 0, 1, 0, 0, 1);

`ifdef BN_COUNTER_SAT_EN
      cyc(1, 0, 1, 1, 8, 1);
      for (int i = 0; i < 3; i++)
         cyc(1, 1, 1, 0, 0, 0);
      cyc(1, 0, 0, 1, 0, 0);
      cyc(1, 1, 0, 0, 0, 0);
`endif

      for (int i = 0; i < 300; i++)
         cyc($urandom_range(0, 19) != 0,
             $urandom_range(0, 3) != 0,
             $urandom_range(0, 1) == 1,
             $urandom_range(0, 7) == 0,
             int'($urandom_range(0, 15)),
             $urandom_range(0, 7) == 0);

`ifndef BN_COUNTER_SAT_EN
      // two-digit decimal cascade
      @(posedge clock);
      #1;
      c_rst = 1'b1;
      c_ei  = 1'b1;
      pulses = 0;
      chk("casc_init", 32'(hi_q) * 10 + 32'(lo_q), 0);
      for (int i = 0; i < 100; i++) begin
         chk("casc_eu", 32'(hi_eu), 32'(i == 99));
         if (hi_eu)
            pulses++;
         @(posedge clock);
         #1;
         chk("casc_q", 32'(hi_q) * 10 + 32'(lo_q), (i + 1) % 100);
      end
      chk("casc_pulses", pulses, 1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
